// File: rtl/mult_div_if.sv
// Request/result bundle between the datapath control and the HI/LO multiply/divide unit.
// start is a request, taken on a rising edge only while busy=0; done pulses once when hi/lo hold the result.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply (shift-add) / divide (restoring) unit, one iteration per cycle.
// Signed ops run on magnitudes; sign correction and the HI/LO write happen in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_div_if.slave  bus,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, src_q, src_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d, sa_q, sa_d, bz_q, bz_d, dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, shifted, trial;
    logic [2*WIDTH-1:0] prod;

    // op[0]=1 selects the unsigned variants, so magnitudes are taken only when it is clear
    assign mag_a   = (~bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b   = (~bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd_q};
    assign prod    = {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        src_d    = src_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        bz_d     = bz_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (!bus.op[2]) begin
                        op_d     = bus.op[1:0];
                        src_d    = bus.a;
                        bz_d     = (bus.b == '0);
                        neg_d    = ~bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        sa_d     = ~bus.op[0] & bus.a[WIDTH-1];
                        dz_d     = 1'b0;
                        acc_hi_d = '0;
                        cnt_d    = '0;
                        // Divide shifts the dividend through acc_lo; multiply shifts the multiplier
                        acc_lo_d = bus.op[1] ? mag_a : mag_b;
                        opnd_d   = bus.op[1] ? mag_b : mag_a;
                        state_d  = S_CALC;
                    end else if (bus.op[1:0] == 2'b00) begin
                        hi_d = bus.a;
                    end else if (bus.op[1:0] == 2'b01) begin
                        lo_d = bus.a;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    if (!trial[WIDTH]) begin
                        acc_hi_d = trial[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = shifted[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = sum[WIDTH:1];
                    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (op_q[1]) begin
                    if (bz_q) begin
                        lo_d = '1;
                        hi_d = src_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                        hi_d = sa_q ? -acc_hi_q : acc_hi_q;
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? -prod : prod;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            src_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bz_q     <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            src_q    <= src_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            bz_q     <= bz_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = (state_q == S_DONE) && dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign state_o      = state_q;
endmodule
